obuf_arb_ctrl: RTL and testbench

- Output-side counterpart of the per-input request controller.
- One instance per router output port (N/W/S/E/B).
- Arbitrates the 5 per-input request lines for this port and issues a one-hot grant.
- Captures the granted payload into a 2-entry output buffer and drives the outgoing link with a valid/ready handshake toward the next hop's input buffer.

---
 rtl/obuf_arb_ctrl_pkg.sv | 20 ++
 rtl/obuf_arb_ctrl_rr_arb5.sv | 58 +++++
 rtl/obuf_arb_ctrl.sv | 84 ++++++++
 tb/tb_obuf_arb_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuf_arb_ctrl_pkg.sv
// Shared constants for the router output-port controller: input direction indices and default widths.
// Also holds the mod-5 wrap helper used by the rotating-priority arbiter.
package obuf_arb_ctrl_pkg;

   localparam int NIN        = 5;
   localparam int PYLD_W_DEF = 23;

   localparam logic [2:0] DIR_N = 3'd0;
   localparam logic [2:0] DIR_W = 3'd1;
   localparam logic [2:0] DIR_S = 3'd2;
   localparam logic [2:0] DIR_E = 3'd3;
   localparam logic [2:0] DIR_B = 3'd4;

   function automatic logic [2:0] wrap5(input logic [3:0] v);
      logic [3:0] t;
      t = (v >= 4'd5) ? v - 4'd5 : v;
      return t[2:0];
   endfunction

endpackage

// File: rtl/obuf_arb_ctrl_rr_arb5.sv
// 5-way one-hot arbiter, combinational grant gated by en_i; rotating priority with OBUF_RR_EN,
// otherwise fixed priority N>W>S>E>B and no state at all.
module rr_arb5
   import obuf_arb_ctrl_pkg::*;
(
`ifdef OBUF_RR_EN
   input  logic           clk,
   input  logic           rst_n,
`endif
   input  logic           en_i,
   input  logic [NIN-1:0] req_i,
   output logic [NIN-1:0] gnt_o
);

   logic found;

`ifdef OBUF_RR_EN
   logic [2:0] ptr_q, ptr_d, win, idx;

   // Search upward from the pointer; the first requester met wins.
   always_comb begin
      gnt_o = '0;
      win   = ptr_q;
      idx   = ptr_q;
      found = 1'b0;
      for (int k = 0; k < NIN; k++) begin
         idx = wrap5({1'b0, ptr_q} + 4'(k));
         if (en_i && !found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            win        = idx;
            found      = 1'b1;
         end
      end
   end

   assign ptr_d = wrap5({1'b0, win} + 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= DIR_N;
      end else if (|gnt_o) begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int k = 0; k < NIN; k++) begin
         if (en_i && !found && req_i[k]) begin
            gnt_o[k] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/obuf_arb_ctrl.sv
// Output-port controller: arbitrates 5 inputs into a 2-entry buffer, link valid one cycle after grant.
// obuf_rdy drops only when both entries are full (never from link_rdy); OBUF_RR_EN selects round-robin.
module obuf_arb_ctrl
   import obuf_arb_ctrl_pkg::*;
#(
   parameter int PYLD_W = PYLD_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NIN-1:0]        arb_req,
   input  logic [NIN*PYLD_W-1:0] payload_i,
   output logic [NIN-1:0]        arb_gnt,
   output logic                  obuf_rdy,
   input  logic                  port_dead,
   output logic                  obuf_vld,
   output logic [PYLD_W-1:0]     obuf_payload,
   input  logic                  link_rdy
);

   logic [PYLD_W-1:0] mem_q [2];
   logic [1:0]        cnt_q, cnt_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr, rd;
   logic [PYLD_W-1:0] wr_dat;

   assign obuf_rdy = port_dead | (cnt_q != 2'd2);

   rr_arb5 u_arb (
`ifdef OBUF_RR_EN
      .clk   (clk),
      .rst_n (rst_n),
`endif
      .en_i  (obuf_rdy),
      .req_i (arb_req),
      .gnt_o (arb_gnt)
   );

   assign wr = |arb_gnt;

   always_comb begin
      wr_dat = '0;
      for (int i = 0; i < NIN; i++) begin
         if (arb_gnt[i]) begin
            wr_dat = payload_i[i*PYLD_W +: PYLD_W];
         end
      end
   end

   assign obuf_vld     = (cnt_q != 2'd0) & ~port_dead;
   assign rd           = obuf_vld & link_rdy;
   assign obuf_payload = mem_q[rd_ptr_q];

   // A dead port still grants, but the flit is dropped and the buffer is flushed.
   always_comb begin
      if (port_dead) begin
         cnt_d    = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         cnt_d    = cnt_q + {1'b0, wr} - {1'b0, rd};
         wr_ptr_d = wr_ptr_q ^ wr;
         rd_ptr_d = rd_ptr_q ^ rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (wr && !port_dead) begin
            mem_q[wr_ptr_q] <= wr_dat;
         end
      end
   end

endmodule

// File: tb/tb_obuf_arb_ctrl.sv
// Directed bench for obuf_arb_ctrl; grant-order expectations follow OBUF_RR_EN when it is defined.
module tb_obuf_arb_ctrl;

   localparam int NIN = 5;
   localparam int PW  = 23;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NIN-1:0]    arb_req;
   logic [NIN*PW-1:0] payload_i;
   logic [NIN-1:0]    arb_gnt;
   logic              obuf_rdy;
   logic              port_dead;
   logic              obuf_vld;
   logic [PW-1:0]     obuf_payload;
   logic              link_rdy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   obuf_arb_ctrl #(.PYLD_W(PW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arb_req      (arb_req),
      .payload_i    (payload_i),
      .arb_gnt      (arb_gnt),
      .obuf_rdy     (obuf_rdy),
      .port_dead    (port_dead),
      .obuf_vld     (obuf_vld),
      .obuf_payload (obuf_payload),
      .link_rdy     (link_rdy)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_pay(input int i, input logic [PW-1:0] v);
      payload_i[i*PW +: PW] = v;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      arb_req   = '0;
      port_dead = 1'b0;
      link_rdy  = 1'b1;
      payload_i = '0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      arb_req   = '0;
      port_dead = 1'b0;
      link_rdy  = 1'b0;
      payload_i = '0;
      #3;
      n_checks++; if (arb_gnt !== 5'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 00000", arb_gnt); end
      n_checks++; if (obuf_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", obuf_vld); end
      n_checks++; if (obuf_payload !== 23'h0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", obuf_payload); end
      n_checks++; if (obuf_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", obuf_rdy); end
   endtask

   task automatic test_single();
      apply_reset();
      set_pay(2, 23'h12345);
      arb_req = 5'b00100;
      #1;
      n_checks++; if (arb_gnt !== 5'b00100) begin n_fail++; $display("FAIL single_gnt: got %b want 00100", arb_gnt); end
      tick();
      arb_req = '0;
      #1;
      n_checks++; if (obuf_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld: got %b want 1", obuf_vld); end
      n_checks++; if (obuf_payload !== 23'h12345) begin n_fail++; $display("FAIL single_payload: got %h want 12345", obuf_payload); end
      tick();
      #1;
      n_checks++; if (obuf_vld !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", obuf_vld); end
   endtask

   task automatic test_round_robin();
      logic [4:0]    exp_g [5];
      logic [PW-1:0] exp_p [5];
`ifdef OBUF_RR_EN
      exp_g = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
      exp_p = '{23'h100, 23'h101, 23'h102, 23'h103, 23'h104};
`else
      exp_g = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
      exp_p = '{23'h100, 23'h100, 23'h100, 23'h100, 23'h100};
`endif
      apply_reset();
      for (int i = 0; i < NIN; i++) set_pay(i, 23'(32'h100 + i));
      arb_req = 5'b11111;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++; if (arb_gnt !== exp_g[c]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, arb_gnt, exp_g[c]); end
         if (c > 0) begin
            n_checks++; if (obuf_payload !== exp_p[c-1] || obuf_vld !== 1'b1) begin n_fail++; $display("FAIL rr_out[%0d]: got vld=%b %h want vld=1 %h", c, obuf_vld, obuf_payload, exp_p[c-1]); end
         end
         tick();
      end
      arb_req = '0;
      #1;
      n_checks++; if (obuf_payload !== exp_p[4] || obuf_vld !== 1'b1) begin n_fail++; $display("FAIL rr_last: got vld=%b %h want vld=1 %h", obuf_vld, obuf_payload, exp_p[4]); end
      tick();
      #1;
      n_checks++; if (obuf_vld !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b want 0", obuf_vld); end
   endtask

   task automatic test_backpressure();
      link_rdy = 1'b0;
      set_pay(0, 23'h0AAAA);
      arb_req = 5'b00001;
      #1;
      n_checks++; if (arb_gnt !== 5'b00001) begin n_fail++; $display("FAIL bp_gnt0: got %b want 00001", arb_gnt); end
      tick();
      set_pay(1, 23'h0BBBB);
      arb_req = 5'b00010;
      #1;
      n_checks++; if (arb_gnt !== 5'b00010) begin n_fail++; $display("FAIL bp_gnt1: got %b want 00010", arb_gnt); end
      n_checks++; if (obuf_payload !== 23'h0AAAA || obuf_vld !== 1'b1) begin n_fail++; $display("FAIL bp_head0: got vld=%b %h want vld=1 0aaaa", obuf_vld, obuf_payload); end
      tick();
      set_pay(2, 23'h0CCCC);
      arb_req = 5'b00100;
      #1;
      n_checks++; if (obuf_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_full_rdy: got %b want 0", obuf_rdy); end
      n_checks++; if (arb_gnt !== 5'b00000) begin n_fail++; $display("FAIL bp_full_gnt: got %b want 00000", arb_gnt); end
      tick();
      #1;
      n_checks++; if (arb_gnt !== 5'b00000) begin n_fail++; $display("FAIL bp_hold_gnt: got %b want 00000", arb_gnt); end
      n_checks++; if (obuf_payload !== 23'h0AAAA) begin n_fail++; $display("FAIL bp_stable: got %h want 0aaaa", obuf_payload); end
      link_rdy = 1'b1;
      #1;
      n_checks++; if (obuf_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_path: got %b want 0", obuf_rdy); end
      tick();
      #1;
      n_checks++; if (obuf_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_back: got %b want 1", obuf_rdy); end
      n_checks++; if (obuf_payload !== 23'h0BBBB) begin n_fail++; $display("FAIL bp_head1: got %h want 0bbbb", obuf_payload); end
      n_checks++; if (arb_gnt !== 5'b00100) begin n_fail++; $display("FAIL bp_gnt2: got %b want 00100", arb_gnt); end
      tick();
      arb_req = '0;
      #1;
      n_checks++; if (obuf_payload !== 23'h0CCCC || obuf_vld !== 1'b1) begin n_fail++; $display("FAIL bp_head2: got vld=%b %h want vld=1 0cccc", obuf_vld, obuf_payload); end
      tick();
      #1;
      n_checks++; if (obuf_vld !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", obuf_vld); end
   endtask

   task automatic test_back_to_back();
      logic [PW-1:0] prev;
      prev = '0;
      link_rdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         set_pay(c, 23'(32'h40000 + c * 32'h111));
         arb_req = 5'(1 << c);
         #1;
         n_checks++; if (arb_gnt !== 5'(1 << c)) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b want %b", c, arb_gnt, 5'(1 << c)); end
         if (c > 0) begin
            n_checks++; if (obuf_payload !== prev || obuf_vld !== 1'b1 || obuf_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_out[%0d]: got vld=%b rdy=%b %h want vld=1 rdy=1 %h", c, obuf_vld, obuf_rdy, obuf_payload, prev); end
         end
         prev = 23'(32'h40000 + c * 32'h111);
         tick();
      end
      arb_req = '0;
      #1;
      n_checks++; if (obuf_payload !== 23'h40444) begin n_fail++; $display("FAIL b2b_last: got %h want 40444", obuf_payload); end
      tick();
      #1;
      n_checks++; if (obuf_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", obuf_vld); end
   endtask

   task automatic test_port_dead();
      logic [4:0] exp_d [3];
`ifdef OBUF_RR_EN
      exp_d = '{5'b01000, 5'b10000, 5'b00001};
`else
      exp_d = '{5'b00001, 5'b00001, 5'b00001};
`endif
      apply_reset();
      link_rdy = 1'b0;
      set_pay(0, 23'h11);
      arb_req = 5'b00001;
      tick();
      set_pay(1, 23'h22);
      arb_req = 5'b00010;
      tick();
      arb_req = '0;
      #1;
      n_checks++; if (obuf_vld !== 1'b1 || obuf_rdy !== 1'b0) begin n_fail++; $display("FAIL dead_pre: got vld=%b rdy=%b want vld=1 rdy=0", obuf_vld, obuf_rdy); end
      port_dead = 1'b1;
      arb_req   = 5'b00100;
      #1;
      n_checks++; if (obuf_vld !== 1'b0 || obuf_rdy !== 1'b1) begin n_fail++; $display("FAIL dead_now: got vld=%b rdy=%b want vld=0 rdy=1", obuf_vld, obuf_rdy); end
      n_checks++; if (arb_gnt !== 5'b00100) begin n_fail++; $display("FAIL dead_gnt: got %b want 00100", arb_gnt); end
      tick();
      arb_req = 5'b11111;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if (arb_gnt !== exp_d[c] || obuf_vld !== 1'b0) begin n_fail++; $display("FAIL dead_sink[%0d]: got gnt=%b vld=%b want gnt=%b vld=0", c, arb_gnt, obuf_vld, exp_d[c]); end
         tick();
      end
      port_dead = 1'b0;
      arb_req   = '0;
      link_rdy  = 1'b1;
      #1;
      n_checks++; if (obuf_vld !== 1'b0 || obuf_rdy !== 1'b1) begin n_fail++; $display("FAIL dead_flushed: got vld=%b rdy=%b want vld=0 rdy=1", obuf_vld, obuf_rdy); end
      set_pay(3, 23'h33333);
      arb_req = 5'b01000;
      #1;
      n_checks++; if (arb_gnt !== 5'b01000) begin n_fail++; $display("FAIL dead_restart_gnt: got %b want 01000", arb_gnt); end
      tick();
      arb_req = '0;
      #1;
      n_checks++; if (obuf_vld !== 1'b1 || obuf_payload !== 23'h33333) begin n_fail++; $display("FAIL dead_restart_out: got vld=%b %h want vld=1 33333", obuf_vld, obuf_payload); end
      tick();
      #1;
      n_checks++; if (obuf_vld !== 1'b0) begin n_fail++; $display("FAIL dead_restart_drain: got %b want 0", obuf_vld); end
   endtask

   task automatic test_async_reset();
      link_rdy = 1'b0;
      set_pay(0, 23'h55);
      arb_req = 5'b00001;
      tick();
      set_pay(1, 23'h66);
      arb_req = 5'b00010;
      tick();
      arb_req = '0;
      #1;
      n_checks++; if (obuf_vld !== 1'b1 || obuf_rdy !== 1'b0) begin n_fail++; $display("FAIL arst_pre: got vld=%b rdy=%b want vld=1 rdy=0", obuf_vld, obuf_rdy); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (obuf_vld !== 1'b0 || obuf_rdy !== 1'b1) begin n_fail++; $display("FAIL arst_now: got vld=%b rdy=%b want vld=0 rdy=1", obuf_vld, obuf_rdy); end
      n_checks++; if (obuf_payload !== 23'h0) begin n_fail++; $display("FAIL arst_payload: got %h want 0", obuf_payload); end
      tick();
      tick();
      rst_n    = 1'b1;
      link_rdy = 1'b1;
      set_pay(2, 23'h77777);
      arb_req = 5'b00100;
      #1;
      n_checks++; if (arb_gnt !== 5'b00100) begin n_fail++; $display("FAIL arst_gnt: got %b want 00100", arb_gnt); end
      tick();
      arb_req = '0;
      #1;
      n_checks++; if (obuf_vld !== 1'b1 || obuf_payload !== 23'h77777) begin n_fail++; $display("FAIL arst_out: got vld=%b %h want vld=1 77777", obuf_vld, obuf_payload); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_back_to_back();
      test_port_dead();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
